// File: rtl/bp_axil_wr_arbiter.sv
// ---------------------------------------------------------------------------
// bp_axil_wr_arbiter
//
// Arbitrates num_req_p write requesters onto a single AXI-Lite write master.
// A round-robin grant is taken in idle, the winner's address/data are latched,
// and the AW and W beats are issued together. The two handshakes may complete
// in either order. Each issued write pushes its requester ID into an
// outstanding-ID FIFO of depth credits_p. B responses pop that FIFO and are
// routed back to the requester that issued the write.
//
// Optional feature: define BP_AXIL_WR_ARBITER_STATS_EN to build per-requester
// 32-bit saturating completion counters on stats_o. Without it, stats_o is 0.
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   req_v_i             per-requester write request valid
//   req_addr_i          per-requester address, packed requester 0 in the LSBs
//   req_data_i          per-requester data, packed requester 0 in the LSBs
//   req_ready_and_o     one-hot accept, pulses in the cycle the write issues
//   resp_v_o            one-hot write-response pulse to the issuing requester
//   resp_err_o          high with resp_v_o when bresp is nonzero
//   m_axil_aw*/w*/b*    AXI-Lite write master channels
//   protocol_err_o      sticky: bvalid seen with no write outstanding
//   stats_o             per-requester completion counts, 32 bits each
// ---------------------------------------------------------------------------
module bp_axil_wr_arbiter #(
    parameter int num_req_p    = 2,
    parameter int addr_width_p = 64,
    parameter int data_width_p = 32,
    parameter int credits_p    = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]             req_ready_and_o,
    output logic [num_req_p-1:0]             resp_v_o,
    output logic                             resp_err_o,
    output logic [addr_width_p-1:0]          m_axil_awaddr,
    output logic                             m_axil_awvalid,
    input  logic                             m_axil_awready,
    output logic [2:0]                       m_axil_awprot,
    output logic [data_width_p-1:0]          m_axil_wdata,
    output logic                             m_axil_wvalid,
    input  logic                             m_axil_wready,
    output logic [data_width_p/8-1:0]        m_axil_wstrb,
    input  logic                             m_axil_bvalid,
    output logic                             m_axil_bready,
    input  logic [1:0]                       m_axil_bresp,
    output logic                             protocol_err_o,
    output logic [num_req_p*32-1:0]          stats_o
);

    localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w = (credits_p > 1) ? $clog2(credits_p) : 1;
    localparam int cnt_w = ptr_w + 1;
    localparam logic [id_w:0]  NREQ = (id_w+1)'(num_req_p);
    localparam logic [cnt_w-1:0] NCRED = cnt_w'(credits_p);

    typedef logic [id_w-1:0] id_t;
    typedef enum logic [1:0] {e_idle, e_send, e_addr, e_data} state_e;

    state_e r_state, w_state_n;
    id_t    r_grant;
    id_t    r_rr_ptr;     // first requester examined by the next search
    id_t    w_pick;
    logic   w_found;

    logic [addr_width_p-1:0] r_addr;
    logic [data_width_p-1:0] r_data;

    id_t              r_fifo [credits_p];
    logic [ptr_w-1:0] r_wptr, r_rptr;
    logic [cnt_w-1:0] r_count;
    logic             r_protocol_err;

    logic w_grant_en, w_complete, w_push, w_pop, w_empty, w_full;
    logic w_awvalid, w_wvalid;

    // (base + off) mod num_req_p, for off < num_req_p
    function automatic id_t f_wrap_add(input id_t base, input int off);
        logic [id_w:0] sum;
        sum = {1'b0, base} + off[id_w:0];
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[id_w-1:0];
    endfunction

    function automatic logic [num_req_p-1:0] f_onehot(input id_t id);
        return {{(num_req_p-1){1'b0}}, 1'b1} << id;
    endfunction

    // Round-robin search: walk from r_rr_ptr downward-in-priority; scanning
    // offsets high to low lets the smallest offset win the last assignment.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (req_v_i[f_wrap_add(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap_add(r_rr_ptr, i);
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == NCRED);

    always_comb begin
        w_state_n  = r_state;
        w_awvalid  = 1'b0;
        w_wvalid   = 1'b0;
        w_complete = 1'b0;
        w_grant_en = 1'b0;
        case (r_state)
            e_idle: begin
                if (w_found && !w_full) begin
                    w_grant_en = 1'b1;
                    w_state_n  = e_send;
                end
            end
            e_send: begin
                w_awvalid = 1'b1;
                w_wvalid  = 1'b1;
                if (m_axil_awready && m_axil_wready) begin
                    w_complete = 1'b1;
                    w_state_n  = e_idle;
                end else if (m_axil_awready) begin
                    w_state_n = e_data;
                end else if (m_axil_wready) begin
                    w_state_n = e_addr;
                end
            end
            e_addr: begin
                w_awvalid = 1'b1;
                if (m_axil_awready) begin
                    w_complete = 1'b1;
                    w_state_n  = e_idle;
                end
            end
            e_data: begin
                w_wvalid = 1'b1;
                if (m_axil_wready) begin
                    w_complete = 1'b1;
                    w_state_n  = e_idle;
                end
            end
            default: w_state_n = e_idle;
        endcase
    end

    // Handshake-facing outputs are forced low while reset is held so an
    // abandoned grant can never produce an accept or a beat.
    assign m_axil_awvalid  = w_awvalid && !reset_i;
    assign m_axil_wvalid   = w_wvalid && !reset_i;
    assign m_axil_awaddr   = r_addr;
    assign m_axil_wdata    = r_data;
    assign m_axil_awprot   = 3'b000;
    assign m_axil_wstrb    = '1;
    assign m_axil_bready   = !w_empty && !reset_i;

    assign w_push          = w_complete && !reset_i;
    assign w_pop           = m_axil_bvalid && m_axil_bready;

    assign req_ready_and_o = w_push ? f_onehot(r_grant) : '0;
    assign resp_v_o        = w_pop ? f_onehot(r_fifo[r_rptr]) : '0;
    assign resp_err_o      = w_pop && (m_axil_bresp != 2'b00);
    assign protocol_err_o  = r_protocol_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state        <= e_idle;
            r_grant        <= '0;
            r_rr_ptr       <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_grant_en) begin
                r_grant  <= w_pick;
                r_rr_ptr <= f_wrap_add(w_pick, 1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // bready is low when empty, so this bvalid is left unaccepted
            if (m_axil_bvalid && w_empty) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Payload and ID storage carry no reset; they are only read when the
    // control state says they hold a live entry.
    always_ff @(posedge clk_i) begin
        if (w_grant_en) begin
            r_addr <= req_addr_i[w_pick*addr_width_p +: addr_width_p];
            r_data <= req_data_i[w_pick*data_width_p +: data_width_p];
        end
        if (w_push) begin
            r_fifo[r_wptr] <= r_grant;
        end
    end

`ifdef BP_AXIL_WR_ARBITER_STATS_EN
    logic [31:0] r_stats [num_req_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_req_p; i++) begin
                r_stats[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (resp_v_o[i] && (r_stats[i] != 32'hFFFF_FFFF)) begin
                    r_stats[i] <= r_stats[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stats_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            stats_o[i*32 +: 32] = r_stats[i];
        end
    end
`else
    assign stats_o = '0;
`endif

endmodule
